// File: rtl/vec_checker_pkg.sv
// rtl/vec_checker_pkg.sv - shared state type, latency bound and saturating increment for vec_checker
package vec_checker_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } vc_state_t;

  localparam int LAT_MAX = 7;

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
    return (v >= max_v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/vc_delay.sv
// rtl/vc_delay.sv - expected-value delay line with valid bit; stage 0 aligns with the registered dut_in,
// the LAT further stages match the DUT latency, so LAT=0 passes straight through relative to dut_in.
module vc_delay #(
  parameter int W   = 3,
  parameter int LAT = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data
);

  logic [LAT:0] v_q;
  logic [W-1:0] d_q [LAT+1];

  always_ff @(posedge clk) begin
    if (reset) begin
      v_q <= '0;
    end else begin
      v_q[0] <= in_valid;
      for (int i = 1; i <= LAT; i++) begin
        v_q[i] <= v_q[i-1];
      end
    end
  end

  // Data needs no reset: it is only observed when its valid bit is set.
  always_ff @(posedge clk) begin
    d_q[0] <= in_data;
    for (int i = 1; i <= LAT; i++) begin
      d_q[i] <= d_q[i-1];
    end
  end

  assign out_valid = v_q[LAT];
  assign out_data  = d_q[LAT];

endmodule

// File: rtl/vec_checker.sv
// rtl/vec_checker.sv - test-vector sequencer/checker; VEC_CHECKER_FIRSTFAIL_EN adds fail_idx/fail_val capture.
module vec_checker
  import vec_checker_pkg::*;
#(
  parameter int IN_W  = 5,
  parameter int OUT_W = 3,
  parameter int DEPTH = 32,
  parameter int LAT   = 0,
  parameter int AW    = $clog2(DEPTH),
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_we,
  input  logic [AW-1:0]    load_addr,
  input  logic [IN_W+OUT_W-1:0] load_data,
  input  logic [CW-1:0]    num_vec,
  input  logic             start,
  output logic [IN_W-1:0]  dut_in,
  output logic             dut_in_valid,
  input  logic [OUT_W-1:0] dut_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CW-1:0]    err_cnt,
  output logic [CW-1:0]    vec_cnt
`ifdef VEC_CHECKER_FIRSTFAIL_EN
  ,
  output logic [AW-1:0]    fail_idx,
  output logic [OUT_W-1:0] fail_val
`endif
);

  localparam int VW = IN_W + OUT_W;
  localparam int DW = $clog2(LAT_MAX + 1);
  localparam logic [DW-1:0] DRAIN_INIT = DW'((LAT > 0) ? LAT - 1 : 0);
  localparam logic [31:0]   ERR_MAX    = 32'((1 << CW) - 1);

  logic [VW-1:0]    table_q [DEPTH];
  vc_state_t        state, state_n;
  logic [CW-1:0]    n_q, idx_q, n_clamp, err_n;
  logic [DW-1:0]    drain_q;
  logic [AW-1:0]    rd_addr;
  logic [VW-1:0]    rd_vec;
  logic             accept, last_issue, iss_valid;
  logic             cmp_valid, mismatch;
  logic [OUT_W-1:0] cmp_exp;

  assign n_clamp    = (num_vec > CW'(DEPTH)) ? CW'(DEPTH) : num_vec;
  assign accept     = (state == IDLE) && start;
  assign last_issue = (state == ISSUE) && (idx_q == n_q);
  assign rd_addr    = accept ? '0 : idx_q[AW-1:0];
  assign rd_vec     = table_q[rd_addr];
  assign iss_valid  = (accept && (n_clamp != '0)) || ((state == ISSUE) && !last_issue);
  // Case-inequality so X/Z responses score as mismatches in simulation.
  assign mismatch   = (dut_out !== cmp_exp);
  assign err_n      = (cmp_valid && mismatch) ? CW'(sat_inc(32'(err_cnt), ERR_MAX)) : err_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    busy    = 1'b0;
    done    = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_n = (n_clamp == '0) ? DONE : ISSUE;
      end
      ISSUE: begin
        busy = 1'b1;
        if (last_issue) state_n = (LAT > 0) ? DRAIN : DONE;
      end
      DRAIN: begin
        busy = 1'b1;
        if (drain_q == '0) state_n = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // The table is frozen while a run is in flight and survives reset.
  always_ff @(posedge clk) begin
    if (load_we && !busy) begin
      table_q[load_addr] <= load_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      n_q          <= '0;
      idx_q        <= '0;
      drain_q      <= '0;
      dut_in       <= '0;
      dut_in_valid <= 1'b0;
      err_cnt      <= '0;
      vec_cnt      <= '0;
      pass         <= 1'b0;
    end else begin
      dut_in_valid <= iss_valid;
      if (iss_valid) dut_in <= rd_vec[VW-1:OUT_W];
      if (accept) begin
        n_q     <= n_clamp;
        idx_q   <= CW'(1);
        err_cnt <= '0;
        vec_cnt <= '0;
        pass    <= (n_clamp == '0);
      end else begin
        if ((state == ISSUE) && !last_issue) idx_q <= idx_q + CW'(1);
        if (last_issue) drain_q <= DRAIN_INIT;
        else if (state == DRAIN) drain_q <= drain_q - DW'(1);
        if (cmp_valid) vec_cnt <= vec_cnt + CW'(1);
        err_cnt <= err_n;
        if (state_n == DONE) pass <= (err_n == '0);
      end
    end
  end

  vc_delay #(
    .W   (OUT_W),
    .LAT (LAT)
  ) u_delay (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (iss_valid),
    .in_data   (rd_vec[OUT_W-1:0]),
    .out_valid (cmp_valid),
    .out_data  (cmp_exp)
  );

`ifdef VEC_CHECKER_FIRSTFAIL_EN
  // vec_cnt equals the index of the vector being compared this cycle.
  always_ff @(posedge clk) begin
    if (reset || accept) begin
      fail_idx <= '0;
      fail_val <= '0;
    end else if (cmp_valid && mismatch && (err_cnt == '0)) begin
      fail_idx <= vec_cnt[AW-1:0];
      fail_val <= dut_out;
    end
  end
`endif

endmodule

// File: tb/tb_vec_checker.sv
// tb/tb_vec_checker.sv - randomized self-checking bench: three checkers (LAT 0, 3, 2) against a 4:2 compressor.
module tb_vec_checker;

  localparam int IN_W  = 5;
  localparam int OUT_W = 3;
  localparam int DEPTH = 32;
  localparam int AW    = 5;
  localparam int CW    = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  reset, load_we, start;
  logic [AW-1:0]         load_addr;
  logic [IN_W+OUT_W-1:0] load_data;
  logic [CW-1:0]         num_vec;

  logic [2:0][IN_W-1:0]  din;
  logic [2:0]            vld, busy_o, done_o, pass_o;
  logic [2:0][CW-1:0]    err_o, vc_o;
`ifdef VEC_CHECKER_FIRSTFAIL_EN
  logic [2:0][AW-1:0]    fidx_o;
  logic [2:0][OUT_W-1:0] fval_o;
`endif

  int passed, total;
  logic [4:0]      tbl_stim [DEPTH];
  logic [2:0]      tbl_exp  [DEPTH];
  logic            vld_tr [3][48];
  logic [IN_W-1:0] din_tr [3][48];
  int              vc_tr  [3][48];
  int              done_at [3];
  int              done_cnt [3];

  // Gate-level reference compressor acting as the device under test.
  function automatic logic [2:0] comp_gates(input logic [4:0] s);
    logic s1;
    s1 = s[3] ^ s[2] ^ s[1];
    return {(s1 & s[0]) | (s1 & s[4]) | (s[0] & s[4]),
            (s[3] & s[2]) | (s[3] & s[1]) | (s[2] & s[1]),
            s1 ^ s[0] ^ s[4]};
  endfunction

  // Arithmetic model: Cin+I1+I2+I3+I4 = S + 2*(C + Cout), Cout = majority(I1,I2,I3).
  function automatic logic [2:0] ref_resp(input logic [4:0] s);
    int i123, tot, co, sb, cc;
    i123 = int'(s[3]) + int'(s[2]) + int'(s[1]);
    tot  = i123 + int'(s[0]) + int'(s[4]);
    co   = (i123 >= 2) ? 1 : 0;
    sb   = tot % 2;
    cc   = (tot - sb - 2 * co) / 2;
    return {cc[0], co[0], sb[0]};
  endfunction

  function automatic int lat_of(input int i);
    return (i == 0) ? 0 : ((i == 1) ? 3 : 2);
  endfunction

  function automatic int model_err(input int nc);
    int e = 0;
    for (int k = 0; k < nc; k++) if (tbl_exp[k] != ref_resp(tbl_stim[k])) e++;
    return e;
  endfunction

  function automatic int model_first(input int nc);
    for (int k = 0; k < nc; k++) if (tbl_exp[k] != ref_resp(tbl_stim[k])) return k;
    return 0;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_inst
    logic [OUT_W-1:0] resp;
    if (g == 0) begin : g_comb
      assign resp = comp_gates(din[g]);
    end else begin : g_pipe
      logic [2:0] p1, p2, p3;
      always @(posedge clk) begin
        p1 <= comp_gates(din[g]);
        p2 <= p1;
        p3 <= p2;
      end
      assign resp = p3;
    end
    vec_checker #(
      .IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH),
      .LAT((g == 0) ? 0 : ((g == 1) ? 3 : 2))
    ) u_dut (
      .clk(clk), .reset(reset), .load_we(load_we), .load_addr(load_addr),
      .load_data(load_data), .num_vec(num_vec), .start(start),
      .dut_in(din[g]), .dut_in_valid(vld[g]), .dut_out(resp),
      .busy(busy_o[g]), .done(done_o[g]), .pass(pass_o[g]),
      .err_cnt(err_o[g]), .vec_cnt(vc_o[g])
`ifdef VEC_CHECKER_FIRSTFAIL_EN
      , .fail_idx(fidx_o[g]), .fail_val(fval_o[g])
`endif
    );
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_entry(input int a, input logic [4:0] s, input logic [2:0] e);
    tbl_stim[a] = s;
    tbl_exp[a]  = e;
    load_we   = 1'b1;
    load_addr = AW'(a);
    load_data = {s, e};
    tick();
    load_we = 1'b0;
  endtask

  task automatic fill_table(input int pct);
    logic [4:0] s;
    logic [2:0] e;
    for (int a = 0; a < DEPTH; a++) begin
      s = 5'($urandom);
      e = ref_resp(s);
      if ($urandom_range(0, 99) < pct) e = e ^ 3'($urandom_range(1, 7));
      load_entry(a, s, e);
    end
  endtask

  // Starts a run and records every instance's outputs for nc+8 cycles after acceptance.
  task automatic run(input int n, input bit poke);
    int nc;
    logic [4:0] s;
    nc = (n > DEPTH) ? DEPTH : n;
    for (int i = 0; i < 3; i++) begin
      done_at[i]  = -1;
      done_cnt[i] = 0;
    end
    num_vec = CW'(n);
    start   = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < nc + 8; c++) begin
      for (int i = 0; i < 3; i++) begin
        vld_tr[i][c] = vld[i];
        din_tr[i][c] = din[i];
        vc_tr[i][c]  = int'(vc_o[i]);
        if (done_o[i]) begin
          done_cnt[i]++;
          if (done_at[i] < 0) done_at[i] = c;
        end
      end
      if (poke && c >= 2 && c <= 4) begin
        s = tbl_stim[c + 10];
        start     = 1'b1;
        load_we   = 1'b1;
        load_addr = AW'(c + 10);
        load_data = {s, ~ref_resp(s)};
      end else if (poke && c == nc) begin
        start   = 1'b1;
        load_we = 1'b0;
      end else begin
        start   = 1'b0;
        load_we = 1'b0;
      end
      tick();
    end
    start   = 1'b0;
    load_we = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) tick();
    for (int i = 0; i < 3; i++) begin
      total++;
      if ({din[i], vld[i], busy_o[i], done_o[i], pass_o[i], err_o[i], vc_o[i]} !== '0)
        $display("FAIL reset_state inst%0d: got din=%0d vld=%0d busy=%0d done=%0d pass=%0d err=%0d vec=%0d, want all 0",
                 i, din[i], vld[i], busy_o[i], done_o[i], pass_o[i], err_o[i], vc_o[i]);
      else passed++;
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_full_run();
    int e;
    fill_table(0);
    run(31, 1'b0);
    for (int i = 0; i < 2; i++) begin
      total++;
      if (done_at[i] != 31 + lat_of(i)) $display("FAIL full_done_at inst%0d: got %0d want %0d", i, done_at[i], 31 + lat_of(i));
      else passed++;
      total++;
      if (err_o[i] !== 6'd0 || pass_o[i] !== 1'b1 || vc_o[i] !== 6'd31)
        $display("FAIL full_counts inst%0d: got err=%0d pass=%0d vec=%0d want 0/1/31", i, err_o[i], pass_o[i], vc_o[i]);
      else passed++;
      for (int c = 0; c < 39; c++) begin
        total++;
        if (vld_tr[i][c] !== (c < 31)) $display("FAIL full_valid inst%0d c%0d: got %0d want %0d", i, c, vld_tr[i][c], c < 31);
        else passed++;
        if (c < 31) begin
          total++;
          if (din_tr[i][c] !== tbl_stim[c]) $display("FAIL full_din inst%0d c%0d: got %0d want %0d", i, c, din_tr[i][c], tbl_stim[c]);
          else passed++;
        end
        e = c - lat_of(i);
        e = (e < 0) ? 0 : ((e > 31) ? 31 : e);
        total++;
        if (vc_tr[i][c] != e) $display("FAIL full_vec_cnt inst%0d c%0d: got %0d want %0d", i, c, vc_tr[i][c], e);
        else passed++;
      end
    end
  endtask

  task automatic test_mismatch();
    logic [2:0] orig;
    orig = tbl_exp[5];
    load_entry(5, tbl_stim[5], orig ^ 3'b001);
    run(31, 1'b0);
    for (int i = 0; i < 2; i++) begin
      total++;
      if (err_o[i] !== 6'd1 || pass_o[i] !== 1'b0 || vc_o[i] !== 6'd31)
        $display("FAIL flip_s inst%0d: got err=%0d pass=%0d vec=%0d want 1/0/31", i, err_o[i], pass_o[i], vc_o[i]);
      else passed++;
`ifdef VEC_CHECKER_FIRSTFAIL_EN
      total++;
      if (fidx_o[i] !== 5'd5 || fval_o[i] !== ref_resp(tbl_stim[5]))
        $display("FAIL first_fail inst%0d: got idx=%0d val=%0d want 5/%0d", i, fidx_o[i], fval_o[i], ref_resp(tbl_stim[5]));
      else passed++;
`endif
    end
    load_entry(5, tbl_stim[5], orig);
  endtask

  task automatic test_zero();
    int hi;
    run(0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      hi = 0;
      for (int c = 0; c < 8; c++) if (vld_tr[i][c] !== 1'b0) hi++;
      total++;
      if (done_at[i] != 0 || done_cnt[i] != 1) $display("FAIL zero_done inst%0d: got at=%0d cnt=%0d want 0/1", i, done_at[i], done_cnt[i]);
      else passed++;
      total++;
      if (pass_o[i] !== 1'b1 || vc_o[i] !== 6'd0 || err_o[i] !== 6'd0 || hi != 0)
        $display("FAIL zero_state inst%0d: got pass=%0d vec=%0d err=%0d valid_cycles=%0d want 1/0/0/0", i, pass_o[i], vc_o[i], err_o[i], hi);
      else passed++;
    end
  endtask

  task automatic test_lat();
    int e;
    for (int k = 0; k < 8; k++) load_entry(k, (k % 2) ? 5'h1f : 5'h00, ref_resp((k % 2) ? 5'h1f : 5'h00));
    run(8, 1'b0);
    total++;
    if (done_at[1] != 11 || pass_o[1] !== 1'b1 || err_o[1] !== 6'd0)
      $display("FAIL lat3_run: got done_at=%0d pass=%0d err=%0d want 11/1/0", done_at[1], pass_o[1], err_o[1]);
    else passed++;
    for (int c = 0; c < 16; c++) begin
      e = c - 3;
      e = (e < 0) ? 0 : ((e > 8) ? 8 : e);
      total++;
      if (vc_tr[1][c] != e) $display("FAIL lat3_compare_cycle c%0d: got vec=%0d want %0d", c, vc_tr[1][c], e);
      else passed++;
    end
    total++;
    if (!(err_o[2] >= 6'd7) || pass_o[2] !== 1'b0)
      $display("FAIL lat2_misaligned: got err=%0d pass=%0d want err>=7 pass=0", err_o[2], pass_o[2]);
    else passed++;
    total++;
    if (done_at[0] != 8 || pass_o[0] !== 1'b1)
      $display("FAIL lat0_short: got done_at=%0d pass=%0d want 8/1", done_at[0], pass_o[0]);
    else passed++;
  endtask

  task automatic test_reset_mid();
    int seen;
    num_vec = CW'(16);
    start   = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      total++;
      if ({din[i], vld[i], busy_o[i], done_o[i], pass_o[i], err_o[i], vc_o[i]} !== '0)
        $display("FAIL mid_reset inst%0d: got din=%0d vld=%0d busy=%0d done=%0d pass=%0d err=%0d vec=%0d, want all 0",
                 i, din[i], vld[i], busy_o[i], done_o[i], pass_o[i], err_o[i], vc_o[i]);
      else passed++;
    end
    reset = 1'b0;
    seen  = 0;
    for (int c = 0; c < 20; c++) begin
      if (done_o != 3'b000 || busy_o != 3'b000) seen++;
      tick();
    end
    total++;
    if (seen != 0) $display("FAIL mid_reset_quiet: got %0d active cycles want 0", seen);
    else passed++;
    run(16, 1'b0);
    for (int i = 0; i < 2; i++) begin
      total++;
      if (vc_o[i] !== 6'd16 || err_o[i] !== 6'd0 || pass_o[i] !== 1'b1 || done_at[i] != 16 + lat_of(i))
        $display("FAIL restart inst%0d: got vec=%0d err=%0d pass=%0d done_at=%0d want 16/0/1/%0d",
                 i, vc_o[i], err_o[i], pass_o[i], done_at[i], 16 + lat_of(i));
      else passed++;
    end
  endtask

  task automatic test_busy_ignore();
    fill_table(0);
    load_entry(7, tbl_stim[7], tbl_exp[7] ^ 3'b100);
    for (int r = 0; r < 2; r++) begin
      run(20, r == 0);
      for (int i = 0; i < 2; i++) begin
        total++;
        if (err_o[i] !== 6'd1 || vc_o[i] !== 6'd20 || pass_o[i] !== 1'b0 || done_cnt[i] != 1 || busy_o[i] !== 1'b0)
          $display("FAIL busy_ignore run%0d inst%0d: got err=%0d vec=%0d pass=%0d dones=%0d busy=%0d want 1/20/0/1/0",
                   r, i, err_o[i], vc_o[i], pass_o[i], done_cnt[i], busy_o[i]);
        else passed++;
`ifdef VEC_CHECKER_FIRSTFAIL_EN
        total++;
        if (fidx_o[i] !== 5'd7) $display("FAIL busy_first_idx run%0d inst%0d: got %0d want 7", r, i, fidx_o[i]);
        else passed++;
`endif
      end
    end
  endtask

  task automatic test_random();
    int n, nc, me;
    for (int it = 0; it < 6; it++) begin
      fill_table(20);
      n  = (it == 0) ? 32 : ((it == 1) ? 40 : int'($urandom_range(1, 32)));
      nc = (n > DEPTH) ? DEPTH : n;
      me = model_err(nc);
      run(n, 1'b0);
      for (int i = 0; i < 2; i++) begin
        total++;
        if (done_at[i] != nc + lat_of(i) || done_cnt[i] != 1)
          $display("FAIL rand_done it%0d inst%0d: got at=%0d cnt=%0d want %0d/1", it, i, done_at[i], done_cnt[i], nc + lat_of(i));
        else passed++;
        total++;
        if (int'(err_o[i]) != me || int'(vc_o[i]) != nc || pass_o[i] !== (me == 0))
          $display("FAIL rand_counts it%0d inst%0d: got err=%0d vec=%0d pass=%0d want %0d/%0d/%0d",
                   it, i, err_o[i], vc_o[i], pass_o[i], me, nc, me == 0);
        else passed++;
`ifdef VEC_CHECKER_FIRSTFAIL_EN
        if (me > 0) begin
          total++;
          if (int'(fidx_o[i]) != model_first(nc))
            $display("FAIL rand_first it%0d inst%0d: got %0d want %0d", it, i, fidx_o[i], model_first(nc));
          else passed++;
        end
`endif
      end
    end
  endtask

  initial begin
    reset     = 1'b1;
    load_we   = 1'b0;
    load_addr = '0;
    load_data = '0;
    num_vec   = '0;
    start     = 1'b0;
    passed    = 0;
    total     = 0;
    test_reset();
    test_full_run();
    test_mismatch();
    test_zero();
    test_lat();
    test_reset_mid();
    test_busy_ignore();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
